// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Packs RV32I instruction fields into 32-bit instruction words and queues each
// word with its target instruction-memory address. It sits between a program
// generator (test or boot stimulus) and an instruction-memory write port, so
// programs can be generated and loaded in hardware.
//
// Handshakes (both sides): a transfer completes on a rising edge where valid
// and ready are both high. The producer holds its payload stable while valid
// is high and not yet accepted. in_ready never depends on in_valid or
// out_ready, and out_valid never depends on out_ready, so no combinational
// loop can form through this block.
//
// Optional feature:
//   ENC_RANGE_CHECK_EN  When defined, immediates are range checked per format
//                       (I/S signed 12-bit, B signed 13-bit even, J signed
//                       21-bit even). A violating request is accepted but
//                       dropped, err pulses and the address counter holds.
//                       When undefined, out-of-range bits are truncated and
//                       imm[0] is ignored for B/J.
//
// Parameters:
//   ADDR_WIDTH  width of out_addr and the address counter
//   BASE_ADDR   first address after reset/flush (multiple of 4)
//   DEPTH       output buffer entries (power of two, >= 2)
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous active-high reset
//   flush      in   empty buffer, reload address counter to BASE_ADDR
//   in_valid   in   request present
//   in_ready   out  request can be accepted this cycle
//   op         in   [6:0]  opcode
//   rd/rs1/rs2 in   [4:0]  register indices
//   funct3     in   [2:0]
//   funct7     in   [6:0]
//   imm        in   [31:0] immediate, two's complement
//   out_valid  out  buffered word available
//   out_ready  in   consumer takes word
//   out_instr  out  [31:0] head-entry instruction word
//   out_addr   out  [ADDR_WIDTH-1:0] head-entry address
//   err        out  one-cycle pulse: an accepted request was dropped
//   emitted    out  [15:0] count of words popped, wraps
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0,
  parameter int unsigned            DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            op,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [31:0]           imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  err,
  output logic [15:0]           emitted
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_R,
    FMT_B,
    FMT_J
  } fmt_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]           instr_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem  [DEPTH];

  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  err_q, err_d;
  logic [15:0]           emitted_q, emitted_d;

  // ---------------------------------------------------------------------------
  // Format selection and encoding
  // ---------------------------------------------------------------------------
  fmt_e        fmt;
  logic [2:0]  f3_eff;
  logic [31:0] enc;
  logic        range_ok;

  always_comb begin
    fmt    = FMT_NONE;
    f3_eff = funct3;
    unique case (op)
      OP_LOAD, OP_IMM: fmt = FMT_I;
      OP_JALR: begin
        fmt    = FMT_I;
        f3_eff = 3'b000;   // JALR only defines funct3 = 000
      end
      OP_STORE:  fmt = FMT_S;
      OP_REG:    fmt = FMT_R;
      OP_BRANCH: fmt = FMT_B;
      OP_JAL:    fmt = FMT_J;
      default:   fmt = FMT_NONE;
    endcase
  end

  always_comb begin
    enc = '0;
    unique case (fmt)
      FMT_I: enc = {imm[11:0], rs1, f3_eff, rd, op};
      FMT_S: enc = {imm[11:5], rs2, rs1, f3_eff, imm[4:0], op};
      FMT_R: enc = {funct7, rs2, rs1, f3_eff, rd, op};
      FMT_B: enc = {imm[12], imm[10:5], rs2, rs1, f3_eff, imm[4:1], imm[11], op};
      FMT_J: enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: enc = '0;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // A value fits a signed N-bit field when bits [31:N-1] are all copies of
  // the sign bit.
  always_comb begin
    range_ok = 1'b1;
    unique case (fmt)
      FMT_I, FMT_S: range_ok = (imm[31:11] == {21{imm[31]}});
      FMT_B:        range_ok = (imm[31:12] == {20{imm[31]}}) && !imm[0];
      FMT_J:        range_ok = (imm[31:20] == {12{imm[31]}}) && !imm[0];
      default:      range_ok = 1'b1;
    endcase
  end
`else
  // Upper immediate bits and imm[0] only matter when range checking is on.
  logic unused_imm_bits;
  assign unused_imm_bits = ^{imm[31:21], imm[0]};
  assign range_ok = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  logic accept;
  logic push;
  logic pop;

  // Full blocks input even when a pop happens on the same edge.
  assign in_ready  = !rst && !flush && (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0) && !flush;

  assign accept = in_valid && in_ready;
  assign push   = accept && (fmt != FMT_NONE) && range_ok;
  assign pop    = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    addr_d    = addr_q;
    err_d     = accept && !push;
    emitted_d = emitted_q;

    if (pop) begin
      emitted_d = emitted_q + 16'd1;
    end

    if (flush) begin
      // accept and pop are both forced low during flush via the ready/valid
      // terms, so only the pointer reload is needed here.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      addr_d  = BASE_ADDR;
    end else begin
      if (push) begin
        tail_d = tail_q + PW'(1);
        addr_d = addr_q + ADDR_WIDTH'(4);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      addr_q    <= BASE_ADDR;
      err_q     <= 1'b0;
      emitted_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      emitted_q <= emitted_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail_q] <= enc;
      addr_mem[tail_q]  <= addr_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // When empty, out_addr shows the address the next word will receive, which
  // equals BASE_ADDR right after reset or flush.
  assign out_instr = (count_q != '0) ? instr_mem[head_q] : 32'd0;
  assign out_addr  = (count_q != '0) ? addr_mem[head_q]  : addr_q;
  assign err       = err_q;
  assign emitted   = emitted_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_0100;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;
  logic [15:0] emitted;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] nxt;
  logic [15:0] em;

  // clock / reset
  always #5 clk = ~clk;

  instr_encoder #(
    .ADDR_WIDTH (32),
    .BASE_ADDR  (BASE),
    .DEPTH      (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err       (err),
    .emitted   (emitted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: present one request, wait (bounded) for acceptance
  task automatic send(input logic [6:0] o, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] im);
    int waited = 0;
    op = o; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    while (!in_ready && waited < 20) begin
      step();
      waited++;
    end
    chk("send_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    em = '0;

    // reset state
    step(); step();
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr",  out_addr, BASE);
    chk("rst_err",       {31'd0, err}, 32'd0);
    chk("rst_emitted",   {16'd0, emitted}, 32'd0);
    rst = 1'b0;
    #1;

    // addi x1, x0, 5, one cycle latency
    out_ready = 1'b1;
    send(OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5);
    chk("addi_valid", {31'd0, out_valid}, 32'd1);
    chk("addi_instr", out_instr, 32'h0050_0093);
    chk("addi_addr",  out_addr, BASE);
    step();
    em = em + 16'd1;
    chk("addi_emitted", {16'd0, emitted}, {16'd0, em});
    chk("addi_drained", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // sw x2, 8(x1) then beq x0, x0, -4
    send(OP_STORE, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8);
    send(OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFC);
    chk("sw_instr", out_instr, 32'h0020_A423);
    chk("sw_addr",  out_addr, BASE + 32'd4);
    pop_one();
    chk("beq_instr", out_instr, 32'hFE00_0EE3);
    chk("beq_addr",  out_addr, BASE + 32'd8);
    pop_one();
    em = em + 16'd2;

    // jal x1, 8 then jalr x1, 0(x2) with funct3 forced to 000
    send(OP_JAL, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd8);
    send(OP_JALR, 5'd1, 5'd2, 5'd0, 3'b111, 7'd0, 32'd0);
    chk("jal_instr", out_instr, 32'h0080_00EF);
    chk("jal_addr",  out_addr, BASE + 32'd12);
    pop_one();
    chk("jalr_instr", out_instr, 32'h0001_00E7);
    chk("jalr_addr",  out_addr, BASE + 32'd16);
    pop_one();
    em = em + 16'd2;
    chk("emitted_5", {16'd0, emitted}, {16'd0, em});
    chk("empty_5", {31'd0, out_valid}, 32'd0);

    // illegal opcode: err pulse, nothing enqueued, address unchanged
    send(OP_LUI, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1);
    chk("illegal_err",   {31'd0, err}, 32'd1);
    chk("illegal_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("illegal_err_1cyc", {31'd0, err}, 32'd0);
    send(OP_IMM, 5'd2, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1);
    chk("after_illegal_instr", out_instr, 32'h0010_0113);
    chk("after_illegal_addr",  out_addr, BASE + 32'd20);
    chk("legal_no_err", {31'd0, err}, 32'd0);
    pop_one();
    em = em + 16'd1;
    nxt = BASE + 32'd24;

    // I-type immediate 2048 (out of signed 12-bit range)
    send(OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048);
`ifdef ENC_RANGE_CHECK_EN
    chk("range_err",   {31'd0, err}, 32'd1);
    chk("range_valid", {31'd0, out_valid}, 32'd0);
`else
    chk("trunc_err",   {31'd0, err}, 32'd0);
    chk("trunc_instr", out_instr, 32'h8000_0093);
    chk("trunc_addr",  out_addr, nxt);
    pop_one();
    em = em + 16'd1;
    nxt = nxt + 32'd4;
`endif
    step();

    // fill buffer, 5th request blocked until a pop
    for (int i = 1; i <= 4; i++) begin
      send(OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, i);
    end
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_head_addr",  out_addr, nxt);
    chk("full_head_instr", out_instr, 32'h0010_0093);
    op = OP_IMM; rd = 5'd1; rs1 = 5'd0; funct3 = 3'b000; imm = 32'd5;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    chk("drain1_addr", out_addr, nxt + 32'd4);
    chk("drain1_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("drain2_addr",  out_addr, nxt + 32'd8);
    chk("drain2_instr", out_instr, 32'h0030_0093);
    step();
    chk("drain3_addr", out_addr, nxt + 32'd12);
    step();
    chk("drain4_addr",  out_addr, nxt + 32'd16);
    chk("drain4_instr", out_instr, 32'h0050_0093);
    step();
    out_ready = 1'b0;
    chk("drain_empty", {31'd0, out_valid}, 32'd0);
    em = em + 16'd5;
    chk("drain_emitted", {16'd0, emitted}, {16'd0, em});

    // flush with 3 words buffered; request during flush not accepted
    for (int i = 0; i < 3; i++) begin
      send(OP_LOAD, 5'd3, 5'd1, 5'd0, 3'b010, 7'd0, 32'd0);
    end
    chk("pre_flush_valid", {31'd0, out_valid}, 32'd1);
    flush = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_ready", {31'd0, in_ready}, 32'd0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("post_flush_valid",   {31'd0, out_valid}, 32'd0);
    chk("post_flush_addr",    out_addr, BASE);
    chk("post_flush_emitted", {16'd0, emitted}, {16'd0, em});
    send(OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd7);
    chk("post_flush_instr", out_instr, 32'h0070_0093);
    chk("post_flush_waddr", out_addr, BASE);
    pop_one();

    // reset with 2 buffered words
    send(OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1);
    send(OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_valid",   {31'd0, out_valid}, 32'd0);
    chk("mid_rst_emitted", {16'd0, emitted}, 32'd0);
    chk("mid_rst_addr",    out_addr, BASE);
    send(OP_IMM, 5'd4, 5'd0, 5'd0, 3'b000, 7'd0, 32'd9);
    chk("mid_rst_instr", out_instr, 32'h0090_0213);
    chk("mid_rst_waddr", out_addr, BASE);
    pop_one();
    chk("mid_rst_emit1", {16'd0, emitted}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Inverse of the main decoder: accepts RV32I instruction fields (opcode, register indices, funct3/funct7, full 32-bit immediate), packs them into a 32-bit instruction word per the format implied by the opcode, and queues the result with a target instruction-memory address. It sits between the test/boot stimulus source and the instruction-memory write port, so programs can be generated and loaded in hardware. Input and output both use valid/ready handshakes, with a DEPTH-entry buffer between them.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of out_addr and the internal address counter
- BASE_ADDR, 0, first address assigned after reset/flush; multiple of 4
- DEPTH, 4, output buffer entries; power of two, ≥2

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  empty buffer, reload address counter to BASE_ADDR
- in_valid  in  1  request present
- in_ready  out  1  request can be accepted this cycle
- op  in  7  opcode (0000011, 0100011, 0010011, 0110011, 1100011, 1101111, 1100111 legal)
- rd, rs1, rs2  in  5 each  register indices
- funct3  in  3; funct7  in  7
- imm  in  32  immediate, two's complement
- out_valid  out  1  buffered word available
- out_ready  in  1  consumer takes word
- out_instr  out  32  encoded instruction (head entry)
- out_addr  out  ADDR_WIDTH  address for out_instr
- err  out  1  one-cycle pulse: accepted request dropped
- emitted  out  16  count of words popped, wraps

## Operation
- Format by op: 0000011/0010011 I; 1100111 I with funct3 forced 000; 0100011 S; 0110011 R; 1100011 B; 1101111 J.
- I: imm[11:0],rs1,funct3,rd,op. S: imm[11:5],rs2,rs1,funct3,imm[4:0],op. R: funct7,rs2,rs1,funct3,rd,op.
- B: imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op. J: imm[20],imm[10:1],imm[11],imm[19:12],rd,op.
- Unused fields ignored; imm bits above the format's range ignored (truncated) unless checking enabled.
- Illegal op accepted (handshake completes), not enqueued, err pulses next cycle, address counter unchanged.
- Legal request enqueued with current address counter value; counter += 4, wraps modulo 2^ADDR_WIDTH.
- Buffer: circular, head/tail pointers + occupancy count 0..DEPTH. Head entry drives out_instr/out_addr.

## Timing
- Reset values: in_ready 0 during rst, out_valid 0, out_instr 0, out_addr BASE_ADDR, err 0, emitted 0, count 0.
- in_ready = !rst && !flush && count<DEPTH (no dependence on out_ready; full buffer blocks even with simultaneous pop).
- out_valid = count≠0 && !flush.
- Latency: accept at edge N → out_valid high from cycle N+1 when buffer was empty.
- Push and pop same edge: count unchanged, order preserved.
- err registered: high exactly one cycle after the dropping accept edge.
- emitted increments on each out_valid && out_ready edge.
- flush priority over push/pop: that edge count=0, pointers=0, address=BASE_ADDR; no handshake completes in a flush cycle; emitted not cleared.
- rst mid-operation: all buffered words discarded, next accepted word gets BASE_ADDR.

## Configuration
- ENC_RANGE_CHECK_EN defined: imm range checked — I/S signed 12-bit, B signed 13-bit and even, J signed 21-bit and even; R ignores imm. Violation: request dropped like illegal op, err pulses, counter unchanged.
- Not defined: no range check; out-of-range bits silently truncated, imm[0] ignored for B/J; err only for illegal op.

## Test plan
- op=0010011, rd=1, rs1=0, funct3=0, imm=5, out_ready=1 after reset → out_instr 0x00500093, out_addr BASE_ADDR, one cycle after accept.
- op=0100011, rs1=1, rs2=2, funct3=010, imm=8 → 0x0020A423; then op=1100011, rs1=rs2=0, funct3=0, imm=-4 → 0xFE000EE3 at BASE_ADDR+4.
- op=1101111, rd=1, imm=8 → 0x008000EF; op=1100111, funct3=111, rd=1, rs1=2, imm=0 → 0x000100E7 (funct3 forced 000).
- DEPTH=4, out_ready=0, 5 legal requests → in_ready low after 4th; out_addr sequence BASE, +4, +8, +12; raise out_ready → all drained in order, 5th at +16, emitted=5.
- op=0110111 → err pulse, no enqueue, next legal word at unchanged address; with ENC_RANGE_CHECK_EN, I-type imm=2048 → err, without → encoded imm field 0x800.
- 3 words buffered, assert flush one cycle → out_valid 0, next accept gets BASE_ADDR; rst with 2 buffered → same, emitted=0.
